cpu_clk_ctrl: RTL and testbench

Run-control scheduler for the CPU's divided clock. It owns one programmable prescaler and sequences it through halt, free-run and N-step modes under a valid/ready command interface. It emits a one-cycle clock-enable pulse (tick_en) for the pipeline and a 50% square wave (sclk) for board-visible logic. It sits between the debug/switch front end and the pipeline's global enable.

---
 rtl/cpu_clk_ctrl_pkg.sv | 19 +
 rtl/cpu_clk_ctrl_tick_prescaler.sv | 44 ++++
 rtl/cpu_clk_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU run-control clock scheduler.
package cpu_clk_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [1:0] {
        OP_HALT   = 2'd0,
        OP_RUN    = 2'd1,
        OP_STEP   = 2'd2,
        OP_SETDIV = 2'd3
    } op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_clk_ctrl_tick_prescaler.sv
// Programmable prescaler: wraps every div+1 enabled cycles and toggles sclk on each wrap.
module tick_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             wrap,
    output logic             sclk
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // >= rather than == so a divisor shrunk below the live count still wraps at once
    assign wrap = en && (cnt_q >= div);
    assign sclk = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (wrap) begin
            sclk_d = ~sclk_q;
        end
        if (clr || wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run-control scheduler: halt / free-run / N-step sequencing of the divided CPU clock enable.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 200000,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CNT_W-1:0]   cmd_arg,
    input  logic               abort,
    output logic               tick_en,
    output logic               sclk,
    output logic [STATE_W-1:0] state,
    output logic [STEP_W-1:0]  steps_left,
    output logic               step_done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              done_q, done_d;
    logic              wrap, clr, accept;
    logic [STEP_W-1:0] step_n;

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != ST_HALT),
        .clr   (clr),
        .div   (div_q),
        .wrap  (wrap),
        .sclk  (sclk)
    );

    assign cmd_ready  = rst_n && !abort && (state_q != ST_STEP);
    assign accept     = cmd_valid && cmd_ready;
    assign step_n     = cmd_arg[STEP_W-1:0];
    assign tick_en    = wrap;
    assign state      = state_q;
    assign steps_left = steps_q;
    assign step_done  = done_q;

    // A tick in the same cycle as an accepted command belongs to the old state
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        steps_d = steps_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        if (abort) begin
            state_d = ST_HALT;
            steps_d = '0;
            clr     = 1'b1;
        end else if (accept) begin
            case (op_e'(cmd_op))
                OP_HALT: begin
                    state_d = ST_HALT;
                    clr     = 1'b1;
                end
                OP_RUN: begin
                    state_d = ST_RUN;
                end
                OP_STEP: begin
                    if (step_n == '0) begin
                        state_d = ST_HALT;
                        steps_d = '0;
                        clr     = 1'b1;
                    end else begin
                        state_d = ST_STEP;
                        steps_d = step_n;
                    end
                end
                OP_SETDIV: begin
                    div_d = cmd_arg;
                    clr   = 1'b1;
                end
                default: ;
            endcase
        end else if ((state_q == ST_STEP) && wrap) begin
            if (steps_q == STEP_W'(1)) begin
                state_d = ST_HALT;
                steps_d = '0;
                done_d  = 1'b1;
                clr     = 1'b1;
            end else begin
                steps_d = steps_q - STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HALT;
            div_q   <= CNT_W'(DEF_DIV);
            steps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DEF_DIV=3: vector table plus multi-cycle sequences.
module tb_cpu_clk_ctrl;
    import cpu_clk_ctrl_pkg::*;

    localparam int CNT_W   = 32;
    localparam int STEP_W  = 16;
    localparam int DEF_DIV = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [CNT_W-1:0]  cmd_arg = '0;
    logic              abort = 1'b0;
    logic              tick_en;
    logic              sclk;
    logic [1:0]        state;
    logic [STEP_W-1:0] steps_left;
    logic              step_done;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .abort      (abort),
        .tick_en    (tick_en),
        .sclk       (sclk),
        .state      (state),
        .steps_left (steps_left),
        .step_done  (step_done)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [15:0] arg;
        logic        ab;
        logic        tick;
        logic        sck;
        logic [1:0]  st;
        logic [15:0] sl;
        logic        done;
        logic        rdy;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input logic v, input logic [1:0] op, input logic [15:0] arg, input logic ab,
                        input logic tk, input logic sk, input logic [1:0] st, input logic [15:0] sl,
                        input logic dn, input logic rd);
        vec_t e;
        e.valid = v; e.op = op; e.arg = arg; e.ab = ab;
        e.tick = tk; e.sck = sk; e.st = st; e.sl = sl; e.done = dn; e.rdy = rd;
        vq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] arg, input logic ab);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        abort     = ab;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({tick_en, sclk, state, steps_left, step_done, cmd_ready});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, ticks, bad;
        logic exp_s;

        // STEP 3 from HALT: ticks on rows 4, 8, 12, done on row 13
        push(1, OP_STEP, 3, 0,  0, 0, 2'd0, 0, 0, 1);
        for (int k = 0; k < 3; k++) push(0, OP_HALT, 0, 0,  0, 0, 2'd2, 3, 0, 0);
        push(0, OP_HALT, 0, 0,  1, 0, 2'd2, 3, 0, 0);
        for (int k = 0; k < 3; k++) push(0, OP_HALT, 0, 0,  0, 1, 2'd2, 2, 0, 0);
        push(0, OP_HALT, 0, 0,  1, 1, 2'd2, 2, 0, 0);
        for (int k = 0; k < 3; k++) push(0, OP_HALT, 0, 0,  0, 0, 2'd2, 1, 0, 0);
        push(0, OP_HALT, 0, 0,  1, 0, 2'd2, 1, 0, 0);
        push(0, OP_HALT, 0, 0,  0, 1, 2'd0, 0, 1, 1);
        // STEP 5 aborted on its second tick
        push(1, OP_STEP, 5, 0,  0, 1, 2'd0, 0, 0, 1);
        for (int k = 0; k < 3; k++) push(0, OP_HALT, 0, 0,  0, 1, 2'd2, 5, 0, 0);
        push(0, OP_HALT, 0, 0,  1, 1, 2'd2, 5, 0, 0);
        for (int k = 0; k < 3; k++) push(0, OP_HALT, 0, 0,  0, 0, 2'd2, 4, 0, 0);
        push(0, OP_HALT, 0, 1,  1, 0, 2'd2, 4, 0, 0);
        push(0, OP_HALT, 0, 0,  0, 1, 2'd0, 0, 0, 1);
        push(0, OP_HALT, 0, 0,  0, 1, 2'd0, 0, 0, 1);

        drive(1, OP_RUN, 0, 0);
        next_cycle();
        next_cycle();
        check("reset_state", outs(), 32'd0);
        drive(0, OP_HALT, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].valid, vq[i].op, {16'd0, vq[i].arg}, vq[i].ab);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  32'({vq[i].tick, vq[i].sck, vq[i].st, vq[i].sl, vq[i].done, vq[i].rdy}));
            next_cycle();
        end
        drive(0, OP_HALT, 0, 0);

        // Fresh reset, then free-run for 100 cycles
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        drive(1, OP_RUN, 0, 0);
        @(negedge clk);
        check("run_ready", 32'(cmd_ready), 32'd1);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        first = 0; ticks = 0; bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (tick_en === 1'b1) begin
                ticks++;
                if (first == 0) first = k;
            end
            if (tick_en !== (k % 4 == 0)) bad++;
            if (sclk !== (((k - 1) / 4) % 2 == 1)) bad++;
            next_cycle();
        end
        check("run_first_tick", 32'(first), 32'd4);
        check("run_tick_count", 32'(ticks), 32'd25);
        check("run_pattern", 32'(bad), 32'd0);

        // SETDIV 0 while running: tick every cycle, sclk toggles every cycle
        drive(1, OP_SETDIV, 0, 0);
        @(negedge clk);
        check("setdiv0_accept", 32'({tick_en, sclk, cmd_ready}), 32'b011);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        exp_s = 1'b1; bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (tick_en !== 1'b1 || sclk !== exp_s) bad++;
            exp_s = ~exp_s;
            next_cycle();
        end
        check("div0_every_cycle", 32'(bad), 32'd0);

        // Back to div 3, then SETDIV 9 with the count at 2
        drive(1, OP_SETDIV, 3, 0);
        @(negedge clk);
        check("setdiv3_tick", 32'({tick_en, sclk}), 32'b11);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        next_cycle();
        next_cycle();
        drive(1, OP_SETDIV, 9, 0);
        @(negedge clk);
        check("setdiv9_cnt2", 32'({tick_en, sclk, cmd_ready}), 32'b001);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        ticks = 0; bad = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (tick_en === 1'b1) ticks++;
            if (tick_en !== (k % 10 == 0)) bad++;
            if (sclk !== (k > 10 && k <= 20)) bad++;
            next_cycle();
        end
        check("div9_tick_count", 32'(ticks), 32'd2);
        check("div9_pattern", 32'(bad), 32'd0);

        // STEP 0 while running halts with no tick and no done
        drive(1, OP_STEP, 0, 0);
        @(negedge clk);
        check("step0_accept", 32'({tick_en, cmd_ready}), 32'b01);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("step0_halt%0d", k), outs(), 32'd1);
            next_cycle();
        end

        // Reset asserted mid-RUN with count at 2; divisor must return to 3
        drive(1, OP_RUN, 0, 0);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        next_cycle();
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", outs(), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(1, OP_RUN, 0, 0);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        ticks = 0; bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (tick_en === 1'b1) ticks++;
            if (tick_en !== (k % 4 == 0)) bad++;
            next_cycle();
        end
        check("div_after_reset_ticks", 32'(ticks), 32'd2);
        check("div_after_reset_pattern", 32'(bad), 32'd0);

        // Abort blocks a held RUN command for two cycles
        drive(1, OP_HALT, 0, 0);
        next_cycle();
        drive(1, OP_RUN, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("abort_block%0d", k), 32'({cmd_ready, tick_en, state}), 32'd0);
            next_cycle();
        end
        drive(1, OP_RUN, 0, 0);
        @(negedge clk);
        check("abort_release_ready", 32'({cmd_ready, state}), 32'b100);
        next_cycle();
        drive(0, OP_HALT, 0, 0);
        @(negedge clk);
        check("abort_release_run", 32'(state), 32'(ST_RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
